// File: rtl/pool_layer_pkg.sv
// rtl/pool_layer_pkg.sv - shared types, sizes and ReLU helper for the max-pooling layer
package pool_layer_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ARRAY_SIZE = 6;
  localparam int POOL_SIZE  = ARRAY_SIZE / 2;

  typedef enum logic {
    S_FIRST  = 1'b0,
    S_SECOND = 1'b1
  } state_t;

  // Sign bit set (negatives, -0, negative NaN) clamps to +0; everything else passes
  function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] w);
    return w[DATA_WIDTH-1] ? '0 : w;
  endfunction

endpackage

// File: rtl/fp_relu_max2.sv
// rtl/fp_relu_max2.sv - optional ReLU on two IEEE-754 words followed by a max select
module fp_relu_max2
  import pool_layer_pkg::*;
#(
  parameter bit BYPASS_RELU = 1'b0
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);

  logic [DATA_WIDTH-1:0] a_r;
  logic [DATA_WIDTH-1:0] b_r;

  // Once both operands are non-negative, the float order equals the unsigned
  // order of the raw bits, so a plain integer compare picks the max
  always_comb begin
    a_r = BYPASS_RELU ? a : relu(a);
    b_r = BYPASS_RELU ? b : relu(b);
    y   = (a_r >= b_r) ? a_r : b_r;
  end

endmodule

// File: rtl/pool_layer_max.sv
// rtl/pool_layer_max.sv - ReLU plus 2x2 stride-2 max pooling over streamed feature rows
module pool_layer_max #(
  parameter int DATA_WIDTH  = 32,
  parameter int ARRAY_SIZE  = 6,
  parameter int ARRAY_WIDTH = 3,
  parameter int IDX_WIDTH   = 3
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  valid_in,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]      feature_in,
  input  logic [IDX_WIDTH-1:0]                  idx_in,
  input  logic [ARRAY_WIDTH-1:0]                row_in,
  input  logic                                  fin_in,
  output logic                                  pool_valid,
  output logic [(ARRAY_SIZE/2)*DATA_WIDTH-1:0]  pool_data,
  output logic [IDX_WIDTH-1:0]                  pool_idx,
  output logic [ARRAY_WIDTH-1:0]                pool_row,
  output logic                                  pool_fin,
  output logic                                  pair_drop
);

  import pool_layer_pkg::state_t;
  import pool_layer_pkg::S_FIRST;
  import pool_layer_pkg::S_SECOND;

  localparam int HALF = ARRAY_SIZE / 2;

  state_t                          state_q, state_d;
  logic [DATA_WIDTH-1:0]           buf_q [HALF];
  logic [DATA_WIDTH-1:0]           buf_d [HALF];
  logic [DATA_WIDTH-1:0]           h_word [HALF];
  logic [DATA_WIDTH-1:0]           v_word [HALF];
  logic [IDX_WIDTH-1:0]            idx_q, idx_d;
  logic                            drop_d;
  logic                            valid_d;
  logic [HALF*DATA_WIDTH-1:0]      data_d;
  logic [IDX_WIDTH-1:0]            pidx_d;
  logic [ARRAY_WIDTH-1:0]          prow_d;

  // Horizontal pairs are rectified here; the vertical max sees rectified words only
  for (genvar k = 0; k < HALF; k++) begin : g_pool
    fp_relu_max2 #(.BYPASS_RELU(1'b0)) u_h (
      .a (feature_in[(ARRAY_SIZE-1-2*k)*DATA_WIDTH +: DATA_WIDTH]),
      .b (feature_in[(ARRAY_SIZE-2-2*k)*DATA_WIDTH +: DATA_WIDTH]),
      .y (h_word[k])
    );
    fp_relu_max2 #(.BYPASS_RELU(1'b1)) u_v (
      .a (buf_q[k]),
      .b (h_word[k]),
      .y (v_word[k])
    );
  end

  // Pair FSM: hold the first row, pool on a matching second row, drop on mismatch or fin
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    drop_d  = pair_drop;
    valid_d = 1'b0;
    data_d  = '0;
    pidx_d  = '0;
    prow_d  = '0;
    if (valid_in) begin
      if (state_q == S_SECOND && idx_in == idx_q) begin
        valid_d = 1'b1;
        for (int k = 0; k < HALF; k++) begin
          data_d[(HALF-1-k)*DATA_WIDTH +: DATA_WIDTH] = v_word[k];
        end
        pidx_d  = idx_q;
        prow_d  = row_in >> 1;
        state_d = S_FIRST;
      end else begin
        if (state_q == S_SECOND) begin
          drop_d = 1'b1;
        end
        buf_d   = h_word;
        idx_d   = idx_in;
        state_d = S_SECOND;
      end
    end
    if (fin_in) begin
      if (state_d == S_SECOND) begin
        drop_d = 1'b1;
      end
      state_d = S_FIRST;
    end
  end

  // State, row buffer and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FIRST;
      idx_q      <= '0;
      pair_drop  <= 1'b0;
      pool_valid <= 1'b0;
      pool_data  <= '0;
      pool_idx   <= '0;
      pool_row   <= '0;
      pool_fin   <= 1'b0;
      for (int k = 0; k < HALF; k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pair_drop  <= drop_d;
      pool_valid <= valid_d;
      pool_data  <= data_d;
      pool_idx   <= pidx_d;
      pool_row   <= prow_d;
      pool_fin   <= fin_in;
      for (int k = 0; k < HALF; k++) begin
        buf_q[k] <= buf_d[k];
      end
    end
  end

endmodule

// File: tb/tb_pool_layer_max.sv
// tb/tb_pool_layer_max.sv - self-checking bench for pool_layer_max
module tb_pool_layer_max;

  localparam int DW = 32;
  localparam int AS = 6;
  localparam int PS = 3;
  localparam int AW = 3;
  localparam int IW = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                valid_in;
  logic [AS*DW-1:0]    feature_in;
  logic [IW-1:0]       idx_in;
  logic [AW-1:0]       row_in;
  logic                fin_in;
  logic                pool_valid;
  logic [PS*DW-1:0]    pool_data;
  logic [IW-1:0]       pool_idx;
  logic [AW-1:0]       pool_row;
  logic                pool_fin;
  logic                pair_drop;

  pool_layer_max dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .feature_in (feature_in),
    .idx_in     (idx_in),
    .row_in     (row_in),
    .fin_in     (fin_in),
    .pool_valid (pool_valid),
    .pool_data  (pool_data),
    .pool_idx   (pool_idx),
    .pool_row   (pool_row),
    .pool_fin   (pool_fin),
    .pair_drop  (pair_drop)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses   = 0;

  // Reference model: a held first row (raw words) plus sticky drop flag
  logic             m_held;
  logic [AS*DW-1:0] m_bus;
  logic [IW-1:0]    m_idx;
  logic             m_drop;
  logic             e_valid;
  logic [PS*DW-1:0] e_data;
  logic [IW-1:0]    e_idx;
  logic [AW-1:0]    e_row;
  logic             e_fin;

  function automatic logic [DW-1:0] word_of(input logic [AS*DW-1:0] bus, input int k);
    return bus[(AS-1-k)*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] relu_f(input logic [DW-1:0] x);
    return x[DW-1] ? 32'h0 : x;
  endfunction

  // Max over the 2x2 window of rectified words, as unsigned bit patterns
  function automatic logic [PS*DW-1:0] pool2x2(input logic [AS*DW-1:0] r0, input logic [AS*DW-1:0] r1);
    logic [PS*DW-1:0] res;
    logic [DW-1:0]    m;
    logic [DW-1:0]    c [4];
    res = '0;
    for (int k = 0; k < PS; k++) begin
      c[0] = relu_f(word_of(r0, 2*k));
      c[1] = relu_f(word_of(r0, 2*k+1));
      c[2] = relu_f(word_of(r1, 2*k));
      c[3] = relu_f(word_of(r1, 2*k+1));
      m = 32'h0;
      for (int j = 0; j < 4; j++) if (c[j] > m) m = c[j];
      res[(PS-1-k)*DW +: DW] = m;
    end
    return res;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    case ($urandom_range(0, 3))
      0:       return $urandom();
      1:       return 32'h8000_0000;
      2:       return {2'b00, 30'($urandom())};
      default: return $urandom() | 32'h8000_0000;
    endcase
  endfunction

  function automatic logic [AS*DW-1:0] rand_row();
    logic [AS*DW-1:0] r;
    for (int k = 0; k < AS; k++) r[(AS-1-k)*DW +: DW] = rand_word();
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string ctx);
    check({ctx, "_valid"}, 128'(pool_valid), 128'(e_valid));
    check({ctx, "_data"},  128'(pool_data),  128'(e_data));
    check({ctx, "_idx"},   128'(pool_idx),   128'(e_idx));
    check({ctx, "_row"},   128'(pool_row),   128'(e_row));
    check({ctx, "_fin"},   128'(pool_fin),   128'(e_fin));
    check({ctx, "_drop"},  128'(pair_drop),  128'(m_drop));
  endtask

  task automatic step(input logic v, input logic [AS*DW-1:0] bus, input logic [IW-1:0] idx,
                      input logic [AW-1:0] row, input logic fin, input string ctx);
    valid_in   = v;
    feature_in = bus;
    idx_in     = idx;
    row_in     = row;
    fin_in     = fin;
    e_valid = 1'b0; e_data = '0; e_idx = '0; e_row = '0; e_fin = fin;
    if (v) begin
      if (m_held && idx == m_idx) begin
        e_valid = 1'b1;
        e_data  = pool2x2(m_bus, bus);
        e_idx   = m_idx;
        e_row   = row >> 1;
        m_held  = 1'b0;
      end else begin
        if (m_held) m_drop = 1'b1;
        m_held = 1'b1;
        m_bus  = bus;
        m_idx  = idx;
      end
    end
    if (fin) begin
      if (m_held) m_drop = 1'b1;
      m_held = 1'b0;
    end
    @(posedge clk);
    #1;
    if (pool_valid) pulses++;
    check_all(ctx);
  endtask

  task automatic idle(input string ctx);
    step(1'b0, rand_row(), 3'($urandom()), 3'($urandom()), 1'b0, ctx);
  endtask

  task automatic apply_reset(input string ctx);
    rst_n = 1'b0;
    m_held = 1'b0; m_drop = 1'b0; m_bus = '0; m_idx = '0;
    e_valid = 1'b0; e_data = '0; e_idx = '0; e_row = '0; e_fin = 1'b0;
    valid_in = 1'b0; fin_in = 1'b0;
    #1;
    check_all({ctx, "_async"});
    @(posedge clk);
    #1;
    check_all({ctx, "_held"});
    rst_n = 1'b1;
  endtask

  logic [AS*DW-1:0] row_a;
  logic [AS*DW-1:0] row_b;
  logic [AS*DW-1:0] neg_row;

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; fin_in = 1'b0;
    feature_in = '0; idx_in = '0; row_in = '0;
    m_held = 1'b0; m_drop = 1'b0; m_bus = '0; m_idx = '0;
    @(posedge clk);
    #1;
    apply_reset("reset");

    // Basic pool with known values
    row_a = {32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3F000000, 32'h40800000, 32'h3F800000};
    row_b = {32'h3F000000, 32'h3F000000, 32'h40400000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    step(1'b1, row_a, 3'd0, 3'd0, 1'b0, "basic_r0");
    step(1'b1, row_b, 3'd0, 3'd1, 1'b0, "basic_r1");
    check("basic_const", 128'(pool_data), 128'(96'h40000000_40400000_40800000));
    idle("basic_idle");

    // ReLU: all-negative rows pool to zeros
    neg_row = {32'hC0400000, 32'h80000000, 32'hC0400000, 32'h80000000, 32'hFFC00000, 32'hC0400000};
    step(1'b1, neg_row, 3'd1, 3'd2, 1'b0, "relu_r0");
    step(1'b1, {neg_row[AS*DW-1-DW:0], 32'h80000000}, 3'd1, 3'd3, 1'b0, "relu_r1");
    check("relu_const", 128'({pool_valid, pool_data}), 128'({1'b1, 96'h0}));
    idle("relu_idle");

    // Full image back-to-back, then fin
    pulses = 0;
    for (int r = 0; r < 6; r++) step(1'b1, rand_row(), 3'd2, 3'(r), 1'b0, "image_row");
    step(1'b0, rand_row(), 3'd0, 3'd0, 1'b1, "image_fin");
    idle("image_fin_out");
    check("image_pulses", 128'(pulses), 128'(3));
    check("image_no_drop", 128'(pair_drop), 128'(0));

    // Index change drops the held half-pair
    step(1'b1, rand_row(), 3'd0, 3'd0, 1'b0, "idxchg_r0");
    step(1'b1, rand_row(), 3'd1, 3'd0, 1'b0, "idxchg_r1");
    step(1'b1, rand_row(), 3'd1, 3'd1, 1'b0, "idxchg_r2");
    check("idxchg_drop", 128'(pair_drop), 128'(1));
    idle("idxchg_idle");

    // fin with an odd row held, then a normal pair
    apply_reset("reset_fin");
    step(1'b1, rand_row(), 3'd3, 3'd4, 1'b0, "finodd_r0");
    step(1'b0, rand_row(), 3'd0, 3'd0, 1'b1, "finodd_fin");
    idle("finodd_out");
    check("finodd_drop", 128'(pair_drop), 128'(1));
    step(1'b1, rand_row(), 3'd3, 3'd0, 1'b0, "finodd_p0");
    step(1'b1, rand_row(), 3'd3, 3'd1, 1'b0, "finodd_p1");

    // fin coinciding with a second row, then with a first row
    step(1'b1, rand_row(), 3'd4, 3'd2, 1'b0, "finsame_r0");
    step(1'b1, rand_row(), 3'd4, 3'd3, 1'b1, "finsame_r1");
    apply_reset("reset_fin2");
    step(1'b1, rand_row(), 3'd4, 3'd2, 1'b1, "finfirst");
    step(1'b1, rand_row(), 3'd4, 3'd3, 1'b0, "finfirst_next");
    idle("finfirst_idle");

    // Reset mid-pair leaves no trace in the following pair
    step(1'b1, {AS{32'h7F000000}}, 3'd5, 3'd0, 1'b0, "rstmid_r0");
    apply_reset("rstmid");
    step(1'b1, rand_row(), 3'd5, 3'd0, 1'b0, "rstmid_p0");
    step(1'b1, rand_row(), 3'd5, 3'd1, 1'b0, "rstmid_p1");

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 3) != 0), rand_row(), 3'($urandom_range(0, 1)),
           3'($urandom()), ($urandom_range(0, 15) == 0), "random");
    end
    idle("random_tail");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
